// File: rtl/m31_pkg.sv
// Shared Mersenne-31 definitions: modulus, sequencer states and canonicalisation.
// Used by the time-multiplexed vector subtractor and its per-lane subtractor.
package m31_pkg;

   localparam int               M31_W = 31;
   localparam logic [M31_W-1:0] M31_P = 31'h7FFFFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // p itself is the non-canonical encoding of zero
   function automatic logic [M31_W-1:0] m31_canon(input logic [M31_W-1:0] x);
      return (x == M31_P) ? '0 : x;
   endfunction

endpackage

// File: rtl/m31_subtractor.sv
// One-lane M31 subtractor, out = (in1 - in2) mod p, always canonical.
// Purely combinational; no handshake.
module m31_subtractor
   import m31_pkg::*;
(
   input  logic [M31_W-1:0] in1,
   input  logic [M31_W-1:0] in2,
   output logic [M31_W-1:0] out
);

   logic [M31_W-1:0] a;
   logic [M31_W-1:0] b;

   assign a = m31_canon(in1);
   assign b = m31_canon(in2);

   // Borrow case: the 32-bit wrap plus p lands back inside [1, p-1] once truncated
   assign out = (a >= b) ? (a - b)
                         : M31_W'({1'b0, a} - {1'b0, b} + {1'b0, M31_P});

endmodule

// File: rtl/m31_vector_subtractor.sv
// Element-wise M31 vector subtract, LANES lanes reused over BEATS cycles; latency BEATS from accept to out_valid.
// in_ready only in IDLE; result is held stable in DONE until out_ready, blocking new input.
module m31_vector_subtractor
   import m31_pkg::*;
#(
   parameter int WORD_WIDTH  = 31,
   parameter int VECTOR_SIZE = 16,
   parameter int LANES       = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_WIDTH-1:0] vec1   [0:VECTOR_SIZE-1],
   input  logic [WORD_WIDTH-1:0] vec2   [0:VECTOR_SIZE-1],
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_WIDTH-1:0] result [0:VECTOR_SIZE-1]
);

   localparam int BEATS = VECTOR_SIZE / LANES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IDX_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      beat_q, beat_d;
   logic [WORD_WIDTH-1:0] op1_q [0:VECTOR_SIZE-1];
   logic [WORD_WIDTH-1:0] op1_d [0:VECTOR_SIZE-1];
   logic [WORD_WIDTH-1:0] op2_q [0:VECTOR_SIZE-1];
   logic [WORD_WIDTH-1:0] op2_d [0:VECTOR_SIZE-1];
   logic [WORD_WIDTH-1:0] res_q [0:VECTOR_SIZE-1];
   logic [WORD_WIDTH-1:0] res_d [0:VECTOR_SIZE-1];

   logic [WORD_WIDTH-1:0] lane_a [0:LANES-1];
   logic [WORD_WIDTH-1:0] lane_b [0:LANES-1];
   logic [WORD_WIDTH-1:0] lane_d [0:LANES-1];
   logic [IDX_W-1:0]      base;

   // First element of the slice handled in the current beat
   assign base = IDX_W'(beat_q) * IDX_W'(LANES);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_a[l] = op1_q[base + IDX_W'(l)];
      assign lane_b[l] = op2_q[base + IDX_W'(l)];

      m31_subtractor u_sub (
         .in1 (lane_a[l]),
         .in2 (lane_b[l]),
         .out (lane_d[l])
      );
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op1_d   = vec1;
               op2_d   = vec2;
               beat_d  = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int l = 0; l < LANES; l++) begin
               res_d[base + IDX_W'(l)] = lane_d[l];
            end
            beat_d = beat_q + CNT_W'(1);
            if (beat_q == CNT_W'(BEATS - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         beat_q  <= '0;
         op1_q   <= '{default: '0};
         op2_q   <= '{default: '0};
         res_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         res_q   <= res_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = res_q;

endmodule

// File: tb/tb_m31_vector_subtractor.sv
// Randomised and directed bench for m31_vector_subtractor against a timestamp/arithmetic reference model.
module tb_m31_vector_subtractor;

   localparam int     W = 31;
   localparam int     N = 16;
   localparam int     L = 4;
   localparam int     B = N / L;
   localparam longint P = 64'h7FFFFFFF;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b1;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] vec1   [0:N-1];
   logic [W-1:0] vec2   [0:N-1];
   logic [W-1:0] result [0:N-1];

   logic [W-1:0] a [0:N-1];
   logic [W-1:0] b [0:N-1];

   int checks = 0;
   int errors = 0;

   m31_vector_subtractor #(
      .WORD_WIDTH  (W),
      .VECTOR_SIZE (N),
      .LANES       (L)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .vec1      (vec1),
      .vec2      (vec2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   // Field subtraction straight from the definition, in wide signed arithmetic
   function automatic logic [W-1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
      longint xv, yv, r;
      xv = longint'(x);
      yv = longint'(y);
      if (xv == P) xv = 0;
      if (yv == P) yv = 0;
      r = ((xv - yv) % P + P) % P;
      return W'(r);
   endfunction

   // Reference: 0 = accepting, 1 = computing (cycles_left to go), 2 = holding result
   int           mphase      = 0;
   int           cycles_left = 0;
   logic [W-1:0] exp_res [0:N-1] = '{default: '0};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mphase      <= 0;
         cycles_left <= 0;
         for (int i = 0; i < N; i++) exp_res[i] <= '0;
      end else begin
         case (mphase)
            0: if (in_valid) begin
                  for (int i = 0; i < N; i++) exp_res[i] <= ref_sub(vec1[i], vec2[i]);
                  cycles_left <= B;
                  mphase      <= 1;
               end
            1: begin
                  cycles_left <= cycles_left - 1;
                  if (cycles_left == 1) mphase <= 2;
               end
            default: if (out_ready) mphase <= 0;
         endcase
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Compare process: handshake decodes every cycle, result whenever not mid-computation
   always @(negedge clk) begin
      int bad;
      check("in_ready_vs_model", 32'(in_ready), 32'(mphase == 0));
      check("out_valid_vs_model", 32'(out_valid), 32'(mphase == 2));
      if (mphase != 1) begin
         bad = -1;
         for (int i = 0; i < N; i++) if (result[i] !== exp_res[i] && bad < 0) bad = i;
         checks++;
         if (bad >= 0) begin
            errors++;
            $display("FAIL result_vs_model idx=%0d actual=%0h required=%0h t=%0t",
                     bad, result[bad], exp_res[bad], $time);
         end
      end
   end

   task automatic expect_all(input string name, input logic [W-1:0] v);
      int bad;
      bad = -1;
      for (int i = 0; i < N; i++) if (result[i] !== v && bad < 0) bad = i;
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s idx=%0d actual=%0h required=%0h", name, bad, result[bad], v);
      end
   endtask

   task automatic wait_out(input string name);
      int lat;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check(name, 32'(lat), 32'(B));
   endtask

   // Present a/b, wait for acceptance, then measure cycles to out_valid
   task automatic send(input string name);
      int t;
      vec1 = a;
      vec2 = b;
      in_valid = 1'b1;
      t = 0;
      while (in_ready !== 1'b1 && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 20) check({name, "_accept_timeout"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out({name, "_latency"});
   endtask

   task automatic do_vec(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] want);
      for (int i = 0; i < N; i++) begin
         a[i] = x;
         b[i] = y;
      end
      out_ready = 1'b1;
      send(name);
      expect_all(name, want);
      @(posedge clk); #1;
      check({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
      check({name, "_out_valid_drop"}, 32'(out_valid), 32'd0);
   endtask

   function automatic logic [W-1:0] rand_elem();
      case ($urandom_range(0, 5))
         0:       return W'(P);
         1:       return '0;
         2:       return W'(P - 1);
         3:       return W'($urandom_range(0, 3));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         vec1[i] = '0;
         vec2[i] = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      expect_all("reset_result", '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic: each element differs by 10
      for (int i = 0; i < N; i++) begin
         a[i] = W'(i + 10);
         b[i] = W'(i);
      end
      out_ready = 1'b1;
      send("basic");
      expect_all("basic", 31'd10);
      @(posedge clk); #1;
      check("basic_in_ready_back", 32'(in_ready), 32'd1);

      do_vec("wrap_0m1", 31'd0, 31'd1, 31'h7FFFFFFE);
      do_vec("wrap_3", 31'd3, 31'h7FFFFFFE, 31'd4);
      do_vec("noncanon_a", 31'h7FFFFFFF, 31'd5, 31'h7FFFFFFA);
      do_vec("noncanon_b", 31'd5, 31'h7FFFFFFF, 31'd5);
      do_vec("noncanon_both", 31'h7FFFFFFF, 31'h7FFFFFFF, 31'd0);

      // Backpressure: hold DONE while a new vector waits on the inputs
      for (int i = 0; i < N; i++) begin
         a[i] = W'(i + 100);
         b[i] = W'(i);
      end
      out_ready = 1'b0;
      send("bp");
      expect_all("bp_first", 31'd100);
      for (int i = 0; i < N; i++) begin
         vec1[i] = 31'd50;
         vec2[i] = 31'd8;
      end
      in_valid = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         check("bp_out_valid_hold", 32'(out_valid), 32'd1);
         check("bp_in_ready_low", 32'(in_ready), 32'd0);
         expect_all("bp_result_hold", 31'd100);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      check("bp_release_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("bp_new_accepted", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      wait_out("bp_second_latency");
      expect_all("bp_second", 31'd42);
      @(posedge clk); #1;

      // Reset while beat 2 is in progress
      for (int i = 0; i < N; i++) begin
         vec1[i] = 31'd9;
         vec2[i] = 31'd1;
      end
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("run_partial_written", 32'(result[0]), 32'd8);
      rst_n = 1'b0;
      #1;
      check("rst_run_out_valid", 32'(out_valid), 32'd0);
      check("rst_run_in_ready", 32'(in_ready), 32'd1);
      expect_all("rst_run_result", '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_vec("post_rst", 31'd7, 31'd2, 31'd5);

      // Random vectors and random consumer stalls, checked by the compare process
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < N; i++) begin
            a[i] = rand_elem();
            b[i] = rand_elem();
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         out_ready = 1'b0;
         send("rand");
         repeat ($urandom_range(0, 4)) @(posedge clk);
         #1;
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end

      @(posedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
